// File: rtl/kore_pkg.sv
// Shared definitions for the kore execute-datapath register-file responder:
// default geometry and the write-handshake state encoding.
package kore_pkg;

  localparam int KORE_DW   = 32;
  localparam int KORE_AW   = 5;
  localparam int KORE_NREG = 32;
  localparam int KORE_CW   = 16;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACK  = 2'd1,
    W_HOLD = 2'd2
  } w_state_e;

endpackage

// File: rtl/kore_regfile_resp_if.sv
// Operand-read and write-back bus between the function FSM (master) and the
// register-file responder (slave).
interface kore_regfile_resp_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] reg_sel;
  logic          reg_rd;
  logic [DW-1:0] data_bus;
  logic          rd_vld;
  logic [AW-1:0] reg_wt;
  logic [DW-1:0] data_out;
  logic          dout_rdy;
  logic          wr_ack;

  modport master (
    output reg_sel, reg_rd, reg_wt, data_out, dout_rdy,
    input  data_bus, rd_vld, wr_ack
  );

  modport slave (
    input  reg_sel, reg_rd, reg_wt, data_out, dout_rdy,
    output data_bus, rd_vld, wr_ack
  );
endinterface

// File: rtl/kore_rf_array.sv
// Register storage: one write port, one combinational read port. Register 0
// and addresses at or above NREG never store and always read as zero.
module kore_rf_array #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  logic wr_ok;
  logic rd_ok;

  assign wr_ok = we && (waddr != '0) && (32'(waddr) < NREG);
  assign rd_ok = (raddr != '0) && (32'(raddr) < NREG);

  always_comb begin
    // NOTE: default every always_comb output before any condition, otherwise a missed branch infers a latch.
    mem_d = mem_q;
    if (wr_ok) mem_d[waddr[$clog2(NREG)-1:0]] = wdata;
  end

  // NOTE: the array is built from resettable flops (not a RAM macro) because every register must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = rd_ok ? mem_q[raddr[$clog2(NREG)-1:0]] : '0;

endmodule

// File: rtl/kore_regfile_resp.sv
// Register-file responder: registered operand reads with write bypass, a
// one-commit-per-request write handshake, op counter and x0-write error flag.
module kore_regfile_resp
  import kore_pkg::*;
#(
  parameter int DW   = KORE_DW,
  parameter int AW   = KORE_AW,
  parameter int NREG = KORE_NREG,
  parameter int CW   = KORE_CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  kore_regfile_resp_if.slave   bus,
  input  logic                 eop,
  output logic [CW-1:0]        op_cnt,
  output logic                 x0_wr_err,
  input  logic                 err_clr
);

  w_state_e      state_q, state_d;
  logic          commit;
  logic [DW-1:0] rf_rdata;
  logic          bypass;

  logic [DW-1:0] data_bus_q, data_bus_d;
  logic          rd_vld_q, rd_vld_d;
  logic          eop_q, eop_d;
  logic [CW-1:0] op_cnt_q, op_cnt_d;
  logic          err_q, err_d;

  kore_rf_array #(.DW(DW), .AW(AW), .NREG(NREG)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit),
    .waddr (bus.reg_wt),
    .wdata (bus.data_out),
    .raddr (bus.reg_sel),
    .rdata (rf_rdata)
  );

  // Commits happen only on the IDLE->ACK transition, so a held request writes once.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      W_IDLE: if (bus.dout_rdy) begin
        commit  = 1'b1;
        state_d = W_ACK;
      end
      W_ACK:   state_d = bus.dout_rdy ? W_HOLD : W_IDLE;
      W_HOLD:  if (!bus.dout_rdy) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  assign bypass = commit && (bus.reg_wt == bus.reg_sel) &&
                  (bus.reg_sel != '0) && (32'(bus.reg_sel) < NREG);

  always_comb begin
    data_bus_d = data_bus_q;
    rd_vld_d   = bus.reg_rd;
    if (bus.reg_rd) data_bus_d = bypass ? bus.data_out : rf_rdata;

    eop_d    = eop;
    op_cnt_d = op_cnt_q + CW'(eop && !eop_q);

    // A new x0 write outranks a simultaneous clear.
    err_d = err_q;
    if (err_clr)                         err_d = 1'b0;
    if (commit && (bus.reg_wt == '0))    err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= W_IDLE;
      data_bus_q <= '0;
      rd_vld_q   <= 1'b0;
      eop_q      <= 1'b0;
      op_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_bus_q <= data_bus_d;
      rd_vld_q   <= rd_vld_d;
      eop_q      <= eop_d;
      op_cnt_q   <= op_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.data_bus = data_bus_q;
  assign bus.rd_vld   = rd_vld_q;
  assign bus.wr_ack   = (state_q == W_ACK);
  assign op_cnt       = op_cnt_q;
  assign x0_wr_err    = err_q;

endmodule

// File: doc/kore_regfile_resp.md
Name: kore_regfile_resp

Overview:
- Register-file responder on the kore execute datapath; serves the function FSM's operand reads and result write-backs.
- Read: FSM drives reg_sel/reg_rd; responder returns operand on data_bus one cycle later with rd_vld.
- Write: FSM presents reg_wt/data_out with a level dout_rdy; responder commits exactly once per assertion, pulses wr_ack, counts eop-terminated operations.

Parameters:
- DW, 32, data width
- AW, 5, register address width
- NREG, 32, number of registers (must be <= 2**AW)
- CW, 16, op counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- reg_sel  in  AW  read register address
- reg_rd  in  1  read request (level, sampled every cycle)
- data_bus  out  DW  read data, registered
- rd_vld  out  1  data_bus valid (1 cycle after reg_rd)
- reg_wt  in  AW  write register address
- data_out  in  DW  write data
- dout_rdy  in  1  write request, level, held by initiator
- wr_ack  out  1  one-cycle pulse: write committed
- eop  in  1  end-of-operation, level from initiator
- op_cnt  out  CW  completed-operation count
- x0_wr_err  out  1  sticky: write to register 0 attempted
- err_clr  in  1  clears x0_wr_err

Behaviour:
- Reset (async, rst_n=0): all NREG registers=0, data_bus=0, rd_vld=0, wr_ack=0, op_cnt=0, x0_wr_err=0, write FSM=W_IDLE, eop_q=0. Reset mid-write abandons it; no partial commit.
- Register 0 reads as 0; writes to it are dropped, set x0_wr_err, still acked.
- Read: cycle N reg_rd=1 -> cycle N+1 data_bus=rf[reg_sel@N], rd_vld=1. reg_rd=0 -> rd_vld=0, data_bus holds last value.
- reg_sel >= NREG: data_bus=0, rd_vld=1 (no error flag).
- Bypass: commit in cycle N to address A (A!=0, A<NREG) and read of A in cycle N -> data_bus@N+1 = new data_out.
- Write FSM:
  - W_IDLE: dout_rdy=1 -> commit rf[reg_wt]=data_out this edge, wr_ack=1 next cycle, go W_ACK.
  - W_ACK: wr_ack=1 this state only; if dout_rdy=1 go W_HOLD else W_IDLE.
  - W_HOLD: no commits; wait for dout_rdy=0 -> W_IDLE.
  - One commit per dout_rdy high period, regardless of length. Changes to data_out/reg_wt while held are ignored.
  - dout_rdy low exactly one cycle between requests: still only one commit per high period; the next rising level in W_IDLE commits again.
- reg_wt >= NREG: write dropped, still acked, no flag.
- eop: op_cnt increments on eop rising edge (eop=1, eop_q=0). Wraps 2**CW-1 -> 0.
- Error flag priority: set and err_clr in the same cycle -> set wins.

Decomposition:
- Shared package kore_pkg: DW/AW/NREG defaults, write-FSM state enum (W_IDLE=2'd0, W_ACK=2'd1, W_HOLD=2'd2).
- One sub-module: kore_rf_array. Holds the storage array with async reset. Has a 1 write port and 1 combinational read port, with x0 and out-of-range masking.
- Bypass, read register, write FSM, counter and error flag live in the top level.

Test Plan:
- Reset then read r5 -> data_bus=0, rd_vld=1 one cycle after reg_rd.
- dout_rdy held 4 cycles, reg_wt=5, data_out=0xDEADBEEF, then read r5 -> one wr_ack pulse (cycle after dout_rdy rose), data_bus=0xDEADBEEF. Change data_out to 0x1 during hold -> r5 still 0xDEADBEEF.
- Same-cycle write r7=0x12345678 and read r7 -> data_bus=0x12345678 next cycle.
- Write r0=0xFFFFFFFF -> wr_ack pulses, x0_wr_err=1, read r0 = 0. Assert err_clr -> flag=0. Assert err_clr together with a new r0 write -> flag stays 1.
- eop pulsed 3 times, then held high 5 cycles -> op_cnt=4. Preload to 0xFFFF via 65535 pulses, one more -> op_cnt=0.
- Drop rst_n while in W_HOLD after write r9=0xA5 -> r9=0, FSM=W_IDLE, op_cnt=0. Release with dout_rdy=1 -> fresh commit and wr_ack.
